// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage that sits directly after the PC unit. It reads the
//   current PC and issues one word request to instruction memory. The fetched
//   instruction and its PC go to decode over a valid/ready handshake. Only one
//   fetch is in flight at a time, and there is no prefetch.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   pc_i              current PC from the PC unit
//   pc_en_o           one-cycle PC-advance pulse (on accept or flush)
//   flush_i           redirect from execute; abandons the current fetch
//   imem_req_o        memory request, held until granted
//   imem_addr_o       request byte address (pc_i while requesting, else 0)
//   imem_gnt_i        memory accepted the request this cycle
//   imem_rvalid_i     read data valid (only honoured in WAIT)
//   imem_rdata_i      read data
//   if_valid_o        instruction valid to decode
//   if_ready_i        decode accepts
//   if_instr_o        instruction word (NOP_INSTR on fault)
//   if_pc_o           PC of if_instr_o
//   if_fault_o        misaligned PC or response timeout
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic        pc_en_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        if_fault_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // The counter holds the number of WAIT cycles already spent. When it
    // reads TIMEOUT_CYCLES-1, the current cycle is the last permitted one.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_drop;
    logic [31:0]   r_pc_q;
    logic [31:0]   r_instr;
    logic [31:0]   r_pc;
    logic          r_fault;

    logic w_misaligned;
    logic w_req;
    logic w_timeout;
    logic w_resp;

    assign w_misaligned = (pc_i[1:0] != 2'b00);
    // A misaligned PC never reaches memory.
    assign w_req        = (r_state == S_REQ) && !w_misaligned;
    assign w_timeout    = (r_cnt == TO_LAST);
    // A WAIT cycle ends on either a response or a timeout.
    assign w_resp       = imem_rvalid_i || w_timeout;

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_req ? pc_i : 32'h0;

    // A flush that lands on the same cycle as an accept still produces only
    // one pulse. The two conditions are OR-ed into a single cycle.
    assign pc_en_o = flush_i || ((r_state == S_HOLD) && if_ready_i);

    assign if_valid_o = (r_state == S_HOLD);
    assign if_instr_o = r_instr;
    assign if_pc_o    = r_pc;
    assign if_fault_o = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            r_pc_q  <= 32'h0;
            r_instr <= NOP_INSTR;
            r_pc    <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end

                S_REQ: begin
                    if (w_req && imem_gnt_i) begin
                        // A grant is binding even when a flush arrives on
                        // the same cycle. The response must still be
                        // drained, so we go to WAIT and discard the result.
                        r_pc_q  <= pc_i;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                        if (flush_i) begin
                            r_drop <= 1'b1;
                        end
                    end else if (flush_i) begin
                        r_state <= S_REQ;
                    end else if (w_misaligned) begin
                        r_instr <= NOP_INSTR;
                        r_pc    <= pc_i;
                        r_fault <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end

                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_resp) begin
                        r_drop <= 1'b0;
                        if (flush_i || r_drop) begin
                            // The result is stale. Consume it silently and
                            // refetch from the redirected PC.
                            r_state <= S_REQ;
                        end else begin
                            r_pc    <= r_pc_q;
                            r_state <= S_HOLD;
                            if (imem_rvalid_i) begin
                                r_instr <= imem_rdata_i;
                                r_fault <= 1'b0;
                            end else begin
                                r_instr <= NOP_INSTR;
                                r_fault <= 1'b1;
                            end
                        end
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flush_i || if_ready_i) begin
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_fault_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.TIMEOUT_CYCLES(16), .NOP_INSTR(32'h0000_0013)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_fault_o    (if_fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step one clock, then let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req_o}, 32'h0);
        chk({tag, "_addr"},  imem_addr_o,         32'h0);
        chk({tag, "_pcen"},  {31'b0, pc_en_o},    32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'h0);
        chk({tag, "_instr"}, if_instr_o,          32'h0000_0013);
        chk({tag, "_pc"},    if_pc_o,             32'h0);
        chk({tag, "_fault"}, {31'b0, if_fault_o}, 32'h0);
    endtask

    initial begin
        int n;
        pc_i = 32'h0; flush_i = 1'b0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; if_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst");

        // ---- basic fetch at pc 0 ----
        tick(); tick();
        rst_n = 1'b1;                       // IDLE cycle
        #1 chk("idle_req", {31'b0, imem_req_o}, 32'h0);
        tick();                             // REQ (cycle 2)
        imem_gnt_i = 1'b1;
        #1 chk("req0_req", {31'b0, imem_req_o}, 32'h1);
        chk("req0_addr", imem_addr_o, 32'h0);
        tick();                             // WAIT
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
        #1 chk("wait0_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                             // HOLD
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("hold0_valid", {31'b0, if_valid_o}, 32'h1);
        chk("hold0_instr", if_instr_o, 32'h0050_0093);
        chk("hold0_pc", if_pc_o, 32'h0);
        chk("hold0_fault", {31'b0, if_fault_o}, 32'h0);

        // ---- decode stall for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, if_valid_o}, 32'h1);
            chk("stall_instr", if_instr_o, 32'h0050_0093);
            chk("stall_pc", if_pc_o, 32'h0);
            chk("stall_pcen", {31'b0, pc_en_o}, 32'h0);
            tick();
        end
        if_ready_i = 1'b1;
        #1 chk("accept_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                             // REQ with new pc
        if_ready_i = 1'b0; pc_i = 32'h0000_0006;
        #1 chk("after_acc_pcen", {31'b0, pc_en_o}, 32'h0);

        // ---- misaligned PC ----
        chk("mis_req", {31'b0, imem_req_o}, 32'h0);
        chk("mis_addr", imem_addr_o, 32'h0);
        tick();                             // HOLD with fault
        chk("mis_valid", {31'b0, if_valid_o}, 32'h1);
        chk("mis_fault", {31'b0, if_fault_o}, 32'h1);
        chk("mis_instr", if_instr_o, 32'h0000_0013);
        chk("mis_pc", if_pc_o, 32'h0000_0006);
        if_ready_i = 1'b1;
        tick();                             // REQ
        if_ready_i = 1'b0; pc_i = 32'h0000_0008; imem_gnt_i = 1'b1;
        #1 chk("to_req", {31'b0, imem_req_o}, 32'h1);
        chk("to_addr", imem_addr_o, 32'h0000_0008);

        // ---- timeout: exactly 16 WAIT cycles ----
        tick();                             // WAIT cycle 1
        imem_gnt_i = 1'b0;
        n = 0;
        while (!if_valid_o && n < 40) begin
            n++;
            tick();
        end
        chk("to_wait_cycles", 32'(n), 32'd16);
        chk("to_fault", {31'b0, if_fault_o}, 32'h1);
        chk("to_instr", if_instr_o, 32'h0000_0013);
        chk("to_pc", if_pc_o, 32'h0000_0008);
        // Stray response in HOLD must be ignored.
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        #1 chk("stray_valid", {31'b0, if_valid_o}, 32'h1);
        chk("stray_instr", if_instr_o, 32'h0000_0013);
        chk("stray_fault", {31'b0, if_fault_o}, 32'h1);
        if_ready_i = 1'b1;
        tick();                             // REQ
        if_ready_i = 1'b0; pc_i = 32'h0000_000C; imem_gnt_i = 1'b1;
        tick();                             // WAIT

        // ---- flush in WAIT, response 3 cycles later ----
        imem_gnt_i = 1'b0; flush_i = 1'b1;
        #1 chk("fl_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                             // WAIT (drop) 1
        flush_i = 1'b0; pc_i = 32'h0000_0100;
        #1 chk("fl_pcen_off", {31'b0, pc_en_o}, 32'h0);
        chk("fl_valid1", {31'b0, if_valid_o}, 32'h0);
        tick();                             // WAIT 2
        chk("fl_valid2", {31'b0, if_valid_o}, 32'h0);
        chk("fl_pcen2", {31'b0, pc_en_o}, 32'h0);
        tick();                             // WAIT 3: stale response
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
        #1 chk("fl_valid3", {31'b0, if_valid_o}, 32'h0);
        tick();                             // REQ
        imem_rvalid_i = 1'b0;
        #1 chk("fl_drop_valid", {31'b0, if_valid_o}, 32'h0);
        chk("fl_req", {31'b0, imem_req_o}, 32'h1);
        chk("fl_addr", imem_addr_o, 32'h0000_0100);
        imem_gnt_i = 1'b1;
        tick();                             // WAIT
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
        tick();                             // HOLD
        imem_rvalid_i = 1'b0;
        #1 chk("fl_new_valid", {31'b0, if_valid_o}, 32'h1);
        chk("fl_new_instr", if_instr_o, 32'h00A0_0113);
        chk("fl_new_pc", if_pc_o, 32'h0000_0100);

        // ---- flush coincident with accept: single pulse ----
        flush_i = 1'b1; if_ready_i = 1'b1;
        #1 chk("co_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                             // REQ
        flush_i = 1'b0; if_ready_i = 1'b0; pc_i = 32'h0000_0200;
        #1 chk("co_pcen_off", {31'b0, pc_en_o}, 32'h0);
        chk("co_valid", {31'b0, if_valid_o}, 32'h0);
        chk("co_addr", imem_addr_o, 32'h0000_0200);
        imem_gnt_i = 1'b1;
        tick();                             // WAIT

        // ---- reset in WAIT ----
        imem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_vals("rstw");
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
        tick();
        rst_n = 1'b1;                       // IDLE
        #1 chk("rr_idle_valid", {31'b0, if_valid_o}, 32'h0);
        chk("rr_idle_req", {31'b0, imem_req_o}, 32'h0);
        tick();                             // REQ, stray rvalid ignored
        pc_i = 32'h0000_0300;
        #1 chk("rr_req", {31'b0, imem_req_o}, 32'h1);
        chk("rr_addr", imem_addr_o, 32'h0000_0300);
        chk("rr_valid", {31'b0, if_valid_o}, 32'h0);
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        tick();                             // WAIT
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        tick();                             // HOLD
        imem_rvalid_i = 1'b0;
        #1 chk("rr_hold_valid", {31'b0, if_valid_o}, 32'h1);
        chk("rr_hold_instr", if_instr_o, 32'h1234_5678);
        chk("rr_hold_pc", if_pc_o, 32'h0000_0300);
        chk("rr_hold_fault", {31'b0, if_fault_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Consumes the current `pc` and issues one word request to instruction memory. It returns the fetched instruction and its PC to decode over a valid/ready handshake.
- Drives `pc_en_o`, which gates the PC register, so the PC advances only when decode accepts an instruction or a flush redirects fetch.
- One instruction in flight; no prefetch.

Parameters:
- TIMEOUT_CYCLES, 16, cycles waited in WAIT for `imem_rvalid_i` before a fetch fault is declared (must be ≥1).
- NOP_INSTR, 32'h00000013, instruction word substituted on any fault (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_i  in  32  current PC from the PC unit.
- pc_en_o  out  1  PC-advance enable to the PC unit; one-cycle pulse.
- flush_i  in  1  redirect from execute: discard the current fetch; the PC unit loads the target this edge.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request byte address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- if_valid_o  out  1  instruction valid to decode.
- if_ready_i  in  1  decode accepts.
- if_instr_o  out  32  instruction.
- if_pc_o  out  32  PC of `if_instr_o`.
- if_fault_o  out  1  misaligned PC or timeout; `if_instr_o` = NOP_INSTR.

Behaviour:

Reset (async, asserted):
- state=IDLE, `imem_req_o`=0, `imem_addr_o`=0, `pc_en_o`=0.
- `if_valid_o`=0, `if_instr_o`=NOP_INSTR, `if_pc_o`=0, `if_fault_o`=0.
- Timeout counter=0, drop flag=0.
- Reset mid-transaction abandons it; any `imem_rvalid_i` in IDLE/REQ is ignored.

IDLE:
- Exactly one cycle after reset release, then REQ.

REQ:
- `imem_req_o`=1 and `imem_addr_o`=`pc_i` (combinational); otherwise `imem_req_o`=0 and `imem_addr_o`=0.
- If `pc_i[1:0]`≠0: no request is raised. Next state is HOLD with `if_fault_o`=1, `if_instr_o`=NOP_INSTR, `if_pc_o`=`pc_i`.
- On `imem_gnt_i`: latch `pc_i` into `pc_q`, clear the counter, go to WAIT.
- Without grant, remain in REQ. The address may change before grant only on flush; the memory tolerates this.

WAIT:
- The counter increments each cycle.
- On `imem_rvalid_i`: load `if_instr_o`=`imem_rdata_i`, `if_pc_o`=`pc_q`, `if_fault_o`=0, go to HOLD.
- If the counter reaches TIMEOUT_CYCLES without `imem_rvalid_i`: go to HOLD with `if_fault_o`=1, `if_instr_o`=NOP_INSTR, `if_pc_o`=`pc_q`.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1).

HOLD:
- `if_valid_o`=1; `if_instr_o`, `if_pc_o` and `if_fault_o` are held stable until accepted.
- When `if_ready_i`=1: `pc_en_o`=1 that cycle, go to REQ. The new `pc_i` is visible in the REQ cycle.
- Latency: grant-to-valid = 1 cycle after `imem_rvalid_i`. Zero-wait throughput = 1 instruction per 3 cycles (REQ→WAIT→HOLD).

flush_i (highest priority):
- `pc_en_o`=1 in the flush cycle, pulsed once even if HOLD&`if_ready_i` coincides.
- `if_valid_o` falls next cycle.
- In REQ without grant, or in HOLD: next state is REQ.
- In REQ with grant in the same cycle, or in WAIT: set the drop flag and stay in WAIT. When `imem_rvalid_i` or timeout arrives, discard the result without raising `if_valid_o`, clear the drop flag, and go to REQ.
- A flush while the drop flag is already set keeps it set; the stale response is still discarded exactly once.

Handshake rules:
- `if_valid_o` never deasserts without acceptance, except on flush.
- `imem_req_o` stays high until grant.
- `imem_rvalid_i` outside WAIT is ignored.

Test Plan:
- Reset release, `pc_i`=0, memory grants immediately with rdata 0x00500093 one cycle later. Required: `imem_addr_o`=0 in cycle 2; then `if_valid_o`=1 with `if_instr_o`=0x00500093 and `if_pc_o`=0. The `pc_en_o` pulse coincides with `if_ready_i`.
- Decode stalls: hold `if_ready_i`=0 for 5 cycles. Required: `if_valid_o`, `if_instr_o` and `if_pc_o` stable; `pc_en_o`=0 throughout; a single `pc_en_o` pulse on release.
- `pc_i`=0x00000006. Required: no `imem_req_o`; `if_valid_o`=1, `if_fault_o`=1, `if_instr_o`=0x00000013, `if_pc_o`=0x6.
- Grant, then no `imem_rvalid_i`. Required: exactly 16 cycles in WAIT, then `if_fault_o`=1 with NOP; a later stray rvalid is ignored.
- Flush in WAIT, response arrives 3 cycles later. Required: `pc_en_o`=1 in the flush cycle only; the response is discarded; the next request uses the new `pc_i` (e.g. 0x100) and delivers the instruction at `if_pc_o`=0x100.
- `rst_n` asserted in WAIT, then released. Required: all outputs at reset values immediately; the first request is at the current `pc_i`, and no stale instruction is delivered.
